pc_stack: RTL and testbench

Parametrised program counter with an internal hardware return-address stack, the next generation of the fetch-stage PC. It sequences `instruction_address` for instruction memory each cycle, handles jump/call/return/conditional branch, supports pipeline stall, and reports stack overflow/underflow as sticky error flags to the control unit.

---
 rtl/pc_stack.sv | 119 +++++++++++
 tb/tb_pc_stack.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// Fetch-stage program counter with a LIFO return-address stack.
// Supports JUMP/CALL/RET/BRC, pipeline stall, and sticky overflow/underflow flags.
module pc_stack #(
   parameter int INSTR_ADDR_SIZE = 8,
   parameter int STACK_DEPTH = 4,
   parameter logic [INSTR_ADDR_SIZE-1:0] RESET_ADDR = '0
) (
   input  logic                               CLK,
   input  logic                               RST_N,
   input  logic                               stall,
   input  logic [2:0]                         jump_code,
   input  logic                               cond,
   input  logic [INSTR_ADDR_SIZE-1:0]         jump_address,
   output logic [INSTR_ADDR_SIZE-1:0]         instruction_address,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
   output logic                               stack_overflow,
   output logic                               stack_underflow
);

   localparam int CW = $clog2(STACK_DEPTH + 1);

   typedef enum logic [2:0] {
      OP_RESET = 3'd0,
      OP_JUMP  = 3'd1,
      OP_RET   = 3'd2,
      OP_NEXT  = 3'd3,
      OP_CALL  = 3'd4,
      OP_BRC   = 3'd5
   } op_e;

   logic [INSTR_ADDR_SIZE-1:0] pc_q, pc_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       ovf_q, ovf_d;
   logic                       unf_q, unf_d;
   logic [INSTR_ADDR_SIZE-1:0] stack_q [STACK_DEPTH];

   logic [INSTR_ADDR_SIZE-1:0] pc_inc;
   logic [INSTR_ADDR_SIZE-1:0] top;
   logic                       push;
   logic                       full;
   logic                       empty;

   assign pc_inc = pc_q + INSTR_ADDR_SIZE'(1);
   assign full   = (cnt_q == CW'(STACK_DEPTH));
   assign empty  = (cnt_q == '0);

   // Top of stack is the entry just below the count.
   always_comb begin
      top = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (cnt_q == CW'(i + 1)) top = stack_q[i];
      end
   end

   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      push  = 1'b0;
      if (!stall) begin
         case (op_e'(jump_code))
            OP_RESET: begin
               pc_d  = RESET_ADDR;
               cnt_d = '0;
               ovf_d = 1'b0;
               unf_d = 1'b0;
            end
            OP_JUMP: pc_d = jump_address;
            OP_RET: begin
               if (empty) begin
                  unf_d = 1'b1;
               end else begin
                  pc_d  = top;
                  cnt_d = cnt_q - CW'(1);
               end
            end
            OP_CALL: begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  push  = 1'b1;
                  pc_d  = jump_address;
                  cnt_d = cnt_q + CW'(1);
               end
            end
            OP_BRC:  pc_d = cond ? jump_address : pc_inc;
            default: pc_d = pc_inc;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q  <= RESET_ADDR;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Storage needs no reset: entries at or above the count are never read.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (push && cnt_q == CW'(i)) stack_q[i] <= pc_inc;
      end
   end

   assign instruction_address = pc_q;
   assign stack_count         = cnt_q;
   assign stack_overflow      = ovf_q;
   assign stack_underflow     = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: the driver pushes hand-computed expected state,
// a monitor pops and compares on each falling edge or on an explicit sample event.
module tb_pc_stack;

   localparam int W = 13;  // {pc[7:0], count[2:0], overflow, underflow}

   logic       CLK;
   logic       RST_N;
   logic       stall;
   logic [2:0] jump_code;
   logic       cond;
   logic [7:0] jump_address;
   logic [7:0] instruction_address;
   logic [2:0] stack_count;
   logic       stack_overflow;
   logic       stack_underflow;

   pc_stack #(
      .INSTR_ADDR_SIZE(8),
      .STACK_DEPTH(4),
      .RESET_ADDR(8'h10)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .stall(stall),
      .jump_code(jump_code),
      .cond(cond),
      .jump_address(jump_address),
      .instruction_address(instruction_address),
      .stack_count(stack_count),
      .stack_overflow(stack_overflow),
      .stack_underflow(stack_underflow)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   // scoreboard
   logic [W-1:0] exp_q [$];
   int checks = 0;
   int errors = 0;
   event sample_ev;

   task automatic compare(input logic [W-1:0] exp);
      logic [W-1:0] act;
      act = {instruction_address, stack_count, stack_overflow, stack_underflow};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL state #%0d: got pc=%h cnt=%0d ovf=%b unf=%b, required pc=%h cnt=%0d ovf=%b unf=%b",
                  checks, act[12:5], act[4:2], act[1], act[0],
                  exp[12:5], exp[4:2], exp[1], exp[0]);
      end
   endtask

   initial begin
      forever begin
         @(negedge CLK or sample_ev);
         while (exp_q.size() > 0) compare(exp_q.pop_front());
      end
   end

   // driver tasks: called just after a falling edge
   task automatic op(input logic [2:0] code, input logic [7:0] addr, input logic c, input logic s,
                     input logic [7:0] e_pc, input logic [2:0] e_cnt, input logic e_ovf, input logic e_unf);
      jump_code    = code;
      jump_address = addr;
      cond         = c;
      stall        = s;
      @(posedge CLK);
      exp_q.push_back({e_pc, e_cnt, e_ovf, e_unf});
      @(negedge CLK);
   endtask

   task automatic check_now(input logic [7:0] e_pc, input logic [2:0] e_cnt, input logic e_ovf, input logic e_unf);
      exp_q.push_back({e_pc, e_cnt, e_ovf, e_unf});
      ->sample_ev;
      #0;
   endtask

   localparam logic [2:0] RST = 3'd0, JMP = 3'd1, RET = 3'd2, NXT = 3'd3, CALL = 3'd4, BRC = 3'd5;

   initial begin
      RST_N = 1'b1; stall = 1'b0; jump_code = NXT; cond = 1'b0; jump_address = 8'h00;
      // asynchronous reset with no clock edge yet
      #1 RST_N = 1'b0;
      #1 check_now(8'h10, 3'd0, 1'b0, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;

      // NEXT from reset address
      op(NXT,  8'h00, 0, 0, 8'h11, 3'd0, 0, 0);
      op(NXT,  8'h00, 0, 0, 8'h12, 3'd0, 0, 0);
      op(NXT,  8'h00, 0, 0, 8'h13, 3'd0, 0, 0);

      // wrap
      op(JMP,  8'hFF, 0, 0, 8'hFF, 3'd0, 0, 0);
      op(NXT,  8'h00, 0, 0, 8'h00, 3'd0, 0, 0);
      op(JMP,  8'hFF, 0, 0, 8'hFF, 3'd0, 0, 0);
      op(CALL, 8'h40, 0, 0, 8'h40, 3'd1, 0, 0);
      op(RET,  8'h00, 0, 0, 8'h00, 3'd0, 0, 0);

      // nesting
      op(JMP,  8'h05, 0, 0, 8'h05, 3'd0, 0, 0);
      op(CALL, 8'h20, 0, 0, 8'h20, 3'd1, 0, 0);
      op(CALL, 8'h30, 0, 0, 8'h30, 3'd2, 0, 0);
      op(RET,  8'h00, 0, 0, 8'h21, 3'd1, 0, 0);
      op(RET,  8'h00, 0, 0, 8'h06, 3'd0, 0, 0);

      // overflow then underflow
      op(JMP,  8'h00, 0, 0, 8'h00, 3'd0, 0, 0);
      op(CALL, 8'h10, 0, 0, 8'h10, 3'd1, 0, 0);
      op(CALL, 8'h20, 0, 0, 8'h20, 3'd2, 0, 0);
      op(CALL, 8'h30, 0, 0, 8'h30, 3'd3, 0, 0);
      op(CALL, 8'h40, 0, 0, 8'h40, 3'd4, 0, 0);
      op(CALL, 8'h50, 0, 0, 8'h40, 3'd4, 1, 0);
      op(RET,  8'h00, 0, 0, 8'h31, 3'd3, 1, 0);
      op(RET,  8'h00, 0, 0, 8'h21, 3'd2, 1, 0);
      op(RET,  8'h00, 0, 0, 8'h11, 3'd1, 1, 0);
      op(RET,  8'h00, 0, 0, 8'h01, 3'd0, 1, 0);
      op(RET,  8'h00, 0, 0, 8'h01, 3'd0, 1, 1);
      op(NXT,  8'h00, 0, 0, 8'h02, 3'd0, 1, 1);
      op(RST,  8'h00, 0, 1, 8'h02, 3'd0, 1, 1);
      op(RST,  8'h00, 0, 0, 8'h10, 3'd0, 0, 0);

      // stall and BRC
      op(JMP,  8'h08, 0, 0, 8'h08, 3'd0, 0, 0);
      op(CALL, 8'h60, 0, 1, 8'h08, 3'd0, 0, 0);
      op(CALL, 8'h60, 0, 0, 8'h60, 3'd1, 0, 0);
      op(RET,  8'h00, 0, 1, 8'h60, 3'd1, 0, 0);
      op(RST,  8'h00, 0, 1, 8'h60, 3'd1, 0, 0);
      op(RET,  8'h00, 0, 0, 8'h09, 3'd0, 0, 0);
      op(JMP,  8'h08, 0, 0, 8'h08, 3'd0, 0, 0);
      op(BRC,  8'h50, 0, 0, 8'h09, 3'd0, 0, 0);
      op(BRC,  8'h50, 1, 0, 8'h50, 3'd0, 0, 0);
      op(3'd6, 8'h77, 1, 0, 8'h51, 3'd0, 0, 0);
      op(3'd7, 8'h77, 1, 0, 8'h52, 3'd0, 0, 0);

      // async reset mid-run discards the stack
      op(CALL, 8'h70, 0, 0, 8'h70, 3'd1, 0, 0);
      op(CALL, 8'h80, 0, 0, 8'h80, 3'd2, 0, 0);
      #2 RST_N = 1'b0;
      #1 check_now(8'h10, 3'd0, 1'b0, 1'b0);
      jump_code = CALL; jump_address = 8'h99;
      @(negedge CLK);
      check_now(8'h10, 3'd0, 1'b0, 1'b0);
      RST_N = 1'b1;
      op(RET,  8'h00, 0, 0, 8'h10, 3'd0, 0, 1);
      op(NXT,  8'h00, 0, 0, 8'h11, 3'd0, 0, 1);

      @(posedge CLK);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
